fp32_square_iter: RTL and testbench

Iterative IEEE-754 single-precision squaring unit (y = a·a) with valid/ready handshakes on both sides. It is the inverse operation of the combinational square-root block in the same FP library. It reuses the same exception-flag set and default-NaN convention. The radix-2 shift-add mantissa multiplier uses one 24-bit adder, trading latency for area in the iterative/multicycle FP path.

---
 rtl/fp32_pkg.sv | 25 ++
 rtl/fp32_round_pack.sv | 68 ++++++
 rtl/fp32_square_iter.sv | 180 ++++++++++++++++++
 tb/tb_fp32_square_iter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared binary32 constants, square-unit state encoding and helpers for the FP library.
package fp32_pkg;

  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP32_PINF = 32'h7F800000;
  localparam int          BIAS      = 127;

  typedef enum logic [1:0] {IDLE, MUL, ROUND, DONE} state_t;

  // Leading zeros of a 24-bit value; returns 24 for an all-zero input.
  function automatic logic [4:0] count_lz24(input logic [23:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd24;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(23 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fp32_round_pack.sv
// Round-to-nearest-even and pack of a normalized mantissa with guard/sticky into binary32 (sign 0).
module fp32_round_pack
  import fp32_pkg::*;
(
  input  logic              [23:0] mant,
  input  logic                     guard,
  input  logic                     sticky,
  input  logic signed       [9:0]  exp_in,
  output logic              [31:0] result,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     inexact
);

  logic [9:0]  sh;
  logic [50:0] wide;
  logic [23:0] m;
  logic        g;
  logic        s;
  logic        ru;
  logic [24:0] rnd;

  always_comb begin
    result    = '0;
    overflow  = 1'b0;
    underflow = 1'b0;
    inexact   = 1'b0;
    sh        = '0;
    wide      = '0;
    m         = mant;
    g         = guard;
    s         = sticky;
    ru        = 1'b0;
    rnd       = '0;
    if (exp_in >= 10'sd255) begin
      result   = FP32_PINF;
      overflow = 1'b1;
      inexact  = 1'b1;
    end else begin
      if (exp_in <= 10'sd0) begin
        // Denormalize; 26 places already pushes every mantissa bit into sticky.
        sh   = (exp_in <= -10'sd25) ? 10'd26 : $unsigned(10'sd1 - exp_in);
        wide = {mant, guard, 26'b0} >> sh;
        m    = wide[50:27];
        g    = wide[26];
        s    = sticky | (|wide[25:0]);
      end
      ru      = g & (m[0] | s);
      rnd     = {1'b0, m} + {24'b0, ru};
      inexact = g | s;
      if (exp_in <= 10'sd0) begin
        // A carry into bit 23 lands in the exponent field as min-normal.
        result    = {8'b0, rnd[23:0]};
        underflow = inexact;
      end else if (rnd[24]) begin
        if (exp_in == 10'sd254) begin
          result   = FP32_PINF;
          overflow = 1'b1;
        end else begin
          result = {1'b0, exp_in[7:0] + 8'd1, 23'b0};
        end
      end else begin
        result = {1'b0, exp_in[7:0], rnd[22:0]};
      end
    end
  end

endmodule

// File: rtl/fp32_square_iter.sv
// Iterative binary32 squarer: radix-2 shift-add mantissa product over 24 cycles, then one rounding cycle.
module fp32_square_iter
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        exc_invalid,
  output logic        exc_divzero,
  output logic        exc_overflow,
  output logic        exc_underflow,
  output logic        exc_inexact
);

  state_t             state_q, state_d;
  logic        [23:0] mcand_q, mcand_d;
  logic signed [9:0]  exp_q, exp_d;
  logic        [47:0] acc_q, acc_d;
  logic        [4:0]  count_q, count_d;
  logic               is_nan_q, is_nan_d, quiet_q, quiet_d;
  logic               is_inf_q, is_inf_d, is_zero_q, is_zero_d;
  logic        [31:0] y_q, y_d;
  logic               inv_q, inv_d, ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;
  logic               in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  logic        [7:0]  a_exp;
  logic        [22:0] a_frac;
  logic        [4:0]  sub_lz;
  logic        [23:0] addend;
  logic        [24:0] sum;
  logic               p_hi;
  logic        [23:0] rp_mant;
  logic               rp_guard, rp_sticky;
  logic signed [9:0]  rp_exp;
  logic        [31:0] rp_result;
  logic               rp_ovf, rp_unf, rp_inx;
  logic               unused_sign;

  assign unused_sign = a[31];
  assign a_exp       = a[30:23];
  assign a_frac      = a[22:0];
  assign sub_lz      = count_lz24({1'b0, a_frac});

  assign addend = mcand_q[count_q] ? mcand_q : 24'd0;
  assign sum    = {1'b0, acc_q[47:24]} + {1'b0, addend};

  // Product sits in [1,4) with the binary point after bit 46.
  assign p_hi      = acc_q[47];
  assign rp_mant   = p_hi ? acc_q[47:24] : acc_q[46:23];
  assign rp_guard  = p_hi ? acc_q[23] : acc_q[22];
  assign rp_sticky = p_hi ? (|acc_q[22:0]) : (|acc_q[21:0]);
  assign rp_exp    = exp_q + exp_q + 10'(BIAS) + (p_hi ? 10'sd1 : 10'sd0);

  fp32_round_pack u_round_pack (
    .mant      (rp_mant),
    .guard     (rp_guard),
    .sticky    (rp_sticky),
    .exp_in    (rp_exp),
    .result    (rp_result),
    .overflow  (rp_ovf),
    .underflow (rp_unf),
    .inexact   (rp_inx)
  );

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    exp_d     = exp_q;
    acc_d     = acc_q;
    count_d   = count_q;
    is_nan_d  = is_nan_q;
    quiet_d   = quiet_q;
    is_inf_d  = is_inf_q;
    is_zero_d = is_zero_q;
    y_d       = y_q;
    inv_d     = inv_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    inx_d     = inx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          is_nan_d  = (&a_exp) && (|a_frac);
          quiet_d   = a_frac[22];
          is_inf_d  = (&a_exp) && !(|a_frac);
          is_zero_d = !(|a_exp) && !(|a_frac);
          if (a_exp == 8'd0) begin
            mcand_d = {1'b0, a_frac} << sub_lz;
            exp_d   = -10'sd126 - $signed({5'b0, sub_lz});
          end else begin
            mcand_d = {1'b1, a_frac};
            exp_d   = $signed({2'b0, a_exp}) - 10'(BIAS);
          end
          acc_d   = '0;
          count_d = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d   = {sum, acc_q[23:1]};
        count_d = count_q + 5'd1;
        if (count_q == 5'd23) state_d = ROUND;
      end
      ROUND: begin
        y_d   = rp_result;
        inv_d = 1'b0;
        ovf_d = rp_ovf;
        unf_d = rp_unf;
        inx_d = rp_inx;
        if (is_nan_q || is_inf_q || is_zero_q) begin
          y_d   = is_nan_q ? FP32_QNAN : (is_inf_q ? FP32_PINF : 32'd0);
          inv_d = is_nan_q && !quiet_q;
          ovf_d = 1'b0;
          unf_d = 1'b0;
          inx_d = 1'b0;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      exp_q       <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      is_nan_q    <= 1'b0;
      quiet_q     <= 1'b0;
      is_inf_q    <= 1'b0;
      is_zero_q   <= 1'b0;
      y_q         <= '0;
      inv_q       <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inx_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      exp_q       <= exp_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      is_nan_q    <= is_nan_d;
      quiet_q     <= quiet_d;
      is_inf_q    <= is_inf_d;
      is_zero_q   <= is_zero_d;
      y_q         <= y_d;
      inv_q       <= inv_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      inx_q       <= inx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign y             = y_q;
  assign exc_invalid   = inv_q;
  assign exc_divzero   = 1'b0;
  assign exc_overflow  = ovf_q;
  assign exc_underflow = unf_q;
  assign exc_inexact   = inx_q;

endmodule

// File: tb/tb_fp32_square_iter.sv
// Bench for fp32_square_iter: directed and random operands against an exact-integer squaring model.
module tb_fp32_square_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] y;
  logic        exc_invalid, exc_divzero, exc_overflow, exc_underflow, exc_inexact;
  logic [4:0]  flags;

  int total = 0;
  int bad   = 0;

  assign flags = {exc_invalid, exc_divzero, exc_overflow, exc_underflow, exc_inexact};

  always #5 clk = ~clk;

  fp32_square_iter dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .a             (a),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .y             (y),
    .exc_invalid   (exc_invalid),
    .exc_divzero   (exc_divzero),
    .exc_overflow  (exc_overflow),
    .exc_underflow (exc_underflow),
    .exc_inexact   (exc_inexact)
  );

  // Exact model: square the integer significand, then round N*2^k to binary32 with RNE.
  // Flags are {invalid, divzero, overflow, underflow, inexact}.
  function automatic void ref_square(input logic [31:0] op, output logic [31:0] ry, output logic [4:0] rf);
    logic [7:0]  ex;
    logic [22:0] fr;
    logic [63:0] nop, n, r, rem, half;
    int          k, p, x, q, sh, be;
    bit          inx, tiny, up;
    ex = op[30:23];
    fr = op[22:0];
    ry = 32'd0;
    rf = 5'd0;
    if (ex == 8'hFF) begin
      if (fr != 23'd0) begin
        ry    = 32'h7FC00000;
        rf[4] = ~fr[22];
      end else begin
        ry = 32'h7F800000;
      end
      return;
    end
    if (ex == 8'd0 && fr == 23'd0) return;
    if (ex == 8'd0) begin
      nop = {41'd0, fr};
      k   = -298;
    end else begin
      nop = {40'd0, 1'b1, fr};
      k   = 2 * (int'(ex) - 150);
    end
    n = nop * nop;
    p = 0;
    for (int i = 0; i < 64; i++) if (n[i]) p = i;
    x = p + k;
    if (x > 127) begin
      ry = 32'h7F800000;
      rf = 5'b00101;
      return;
    end
    tiny = (x < -126);
    q    = tiny ? -149 : x - 23;
    sh   = q - k;
    up   = 1'b0;
    if (sh <= 0) begin
      r   = n << (-sh);
      inx = 1'b0;
    end else if (sh >= 62) begin
      r   = 64'd0;
      inx = 1'b1;
    end else begin
      r    = n >> sh;
      rem  = n & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      inx  = (rem != 64'd0);
      up   = (rem > half) || (rem == half && r[0]);
    end
    r = r + {63'd0, up};
    if (r == (64'd1 << 24)) begin
      r = 64'd1 << 23;
      q = q + 1;
    end
    if (r >= (64'd1 << 23)) begin
      be = q + 23 + 127;
      if (be >= 255) begin
        ry = 32'h7F800000;
        rf = 5'b00101;
        return;
      end
      ry = {1'b0, 8'(be), r[22:0]};
    end else begin
      ry = {9'd0, r[22:0]};
    end
    rf[1] = tiny && inx;
    rf[0] = inx;
  endfunction

  // Drives one operand and waits for out_valid; the accept edge counts as latency edge 1.
  task automatic run_op(input logic [31:0] op, input bit handshake,
                        output logic [31:0] ry, output logic [4:0] rf, output int lat, output bit ok);
    int  w;
    bit  seen;
    ok   = 1'b1;
    lat  = 0;
    seen = 1'b0;
    w    = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    a        = op;
    in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    #1 in_valid = 1'b0;
    a = $urandom;
    while (!seen && ok) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else if (lat >= 60) ok = 1'b0;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    ry = y;
    rf = flags;
    if (ok && handshake) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (y !== 32'd0) begin bad++; $display("FAIL reset_y got=%h want=00000000", y); end
    total++; if (flags !== 5'd0) begin bad++; $display("FAIL reset_flags got=%b want=00000", flags); end
    @(negedge clk);
    rst = 1'b0;
    $display("reset: in_ready=%b out_valid=%b y=%h", in_ready, out_valid, y);
  endtask

  task automatic test_directed();
    logic [31:0] tin  [10] = '{32'h40400000, 32'h3F800001, 32'h7F7FFFFF, 32'h1F800000, 32'h00000001,
                               32'h7F800001, 32'h7FC00000, 32'hFF800000, 32'h80000000, 32'hC0000000};
    logic [31:0] tout [10] = '{32'h41100000, 32'h3F800002, 32'h7F800000, 32'h00200000, 32'h00000000,
                               32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h40800000};
    logic [4:0]  tfl  [10] = '{5'b00000, 5'b00001, 5'b00101, 5'b00000, 5'b00011,
                               5'b10000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    logic [31:0] ry;
    logic [4:0]  rf;
    int          lat;
    bit          ok;
    for (int i = 0; i < 10; i++) begin
      run_op(tin[i], 1'b1, ry, rf, lat, ok);
      $display("directed a=%h y=%h flags=%b lat=%0d", tin[i], ry, rf, lat);
      total++; if (!ok) begin bad++; $display("FAIL directed_timeout a=%h got=no_out_valid want=out_valid", tin[i]); end
      total++; if (ry !== tout[i]) begin bad++; $display("FAIL directed_y a=%h got=%h want=%h", tin[i], ry, tout[i]); end
      total++; if (rf !== tfl[i]) begin bad++; $display("FAIL directed_flags a=%h got=%b want=%b", tin[i], rf, tfl[i]); end
      total++; if (lat !== 26) begin bad++; $display("FAIL directed_latency a=%h got=%0d want=26", tin[i], lat); end
    end
  endtask

  task automatic test_random();
    logic [31:0] op, ry, ey;
    logic [4:0]  rf, ef;
    int          lat;
    bit          ok;
    for (int i = 0; i < 150; i++) begin
      op = $urandom;
      case ($urandom_range(0, 5))
        0: ;
        1: op[30:23] = 8'($urandom_range(55, 70));
        2: op[30:23] = 8'($urandom_range(185, 195));
        3: op[30:23] = 8'd0;
        4: op[30:23] = 8'hFF;
        default: op[22:0] = 23'($urandom_range(0, 3));
      endcase
      ref_square(op, ey, ef);
      run_op(op, 1'b1, ry, rf, lat, ok);
      $display("random a=%h y=%h flags=%b exp_y=%h exp_flags=%b", op, ry, rf, ey, ef);
      total++; if (!ok) begin bad++; $display("FAIL random_timeout a=%h got=no_out_valid want=out_valid", op); end
      total++; if (ry !== ey) begin bad++; $display("FAIL random_y a=%h got=%h want=%h", op, ry, ey); end
      total++; if (rf !== ef) begin bad++; $display("FAIL random_flags a=%h got=%b want=%b", op, rf, ef); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] op, ry, ey;
    logic [4:0]  rf, ef;
    int          lat;
    bit          ok;
    op = 32'h3FC00001;
    ref_square(op, ey, ef);
    run_op(op, 1'b0, ry, rf, lat, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_timeout got=no_out_valid want=out_valid"); end
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      a        = $urandom;
      @(posedge clk);
      @(negedge clk);
      total++; if (y !== ry) begin bad++; $display("FAIL bp_y_stable cyc=%0d got=%h want=%h", i, y, ry); end
      total++; if (flags !== rf) begin bad++; $display("FAIL bp_flags_stable cyc=%0d got=%b want=%b", i, flags, rf); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid cyc=%0d got=%b want=1", i, out_valid); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", i, in_ready); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    $display("backpressure a=%h y=%h flags=%b", op, ry, rf);
    total++; if (ry !== ey) begin bad++; $display("FAIL bp_y got=%h want=%h", ry, ey); end
    total++; if (rf !== ef) begin bad++; $display("FAIL bp_flags got=%b want=%b", rf, ef); end
    @(negedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_after_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_after_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] ry, ey;
    logic [4:0]  rf, ef;
    int          lat;
    bit          ok;
    @(negedge clk);
    a        = 32'h40400000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_in_ready got=%b want=1", in_ready); end
    total++; if (y !== 32'd0) begin bad++; $display("FAIL rst_mid_y got=%h want=00000000", y); end
    @(negedge clk);
    rst = 1'b0;
    ref_square(32'h3F800001, ey, ef);
    run_op(32'h3F800001, 1'b1, ry, rf, lat, ok);
    $display("reset_midflight next a=3f800001 y=%h flags=%b lat=%0d", ry, rf, lat);
    total++; if (!ok) begin bad++; $display("FAIL rst_mid_timeout got=no_out_valid want=out_valid"); end
    total++; if (ry !== ey) begin bad++; $display("FAIL rst_mid_y_next got=%h want=%h", ry, ey); end
    total++; if (rf !== ef) begin bad++; $display("FAIL rst_mid_flags_next got=%b want=%b", rf, ef); end
    total++; if (lat !== 26) begin bad++; $display("FAIL rst_mid_latency got=%0d want=26", lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] op, ry, ey;
    logic [4:0]  rf, ef;
    int          lat;
    bit          ok;
    for (int i = 0; i < 4; i++) begin
      op = $urandom;
      ref_square(op, ey, ef);
      run_op(op, 1'b1, ry, rf, lat, ok);
      $display("back_to_back a=%h y=%h flags=%b in_ready=%b", op, ry, rf, in_ready);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%b want=1", in_ready); end
      total++; if (ry !== ey) begin bad++; $display("FAIL b2b_y a=%h got=%h want=%h", op, ry, ey); end
      total++; if (rf !== ef) begin bad++; $display("FAIL b2b_flags a=%h got=%b want=%b", op, rf, ef); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midflight();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
